// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: per-frame controller between a receiver wrapper, its RX FIFO and a word stream.
// Latency: rx_ready is synchronized over 2 flops; each word is presented 2 cycles after its FIFO read.
// Backpressure: m_data/m_valid are held while m_ready is low; no further FIFO read is issued until the word transfers.
//
// Ports:
//   clk_100_mhz, rst_n            : clock, synchronous active-low reset
//   rx_ready, rx_data_count,
//   rx_protocol_type              : frame-complete flag (other clock domain) and its frame descriptors
//   fifo_data, fifo_empty,
//   fifo_rd_en                    : RX FIFO read port (data valid one cycle after the strobe)
//   rx_rst_n                      : active-low release pulse to receiver wrapper and FIFO after each frame
//   m_data, m_valid, m_ready,
//   m_last                        : outgoing word stream, one word per m_valid && m_ready
//   frame_len, frame_type         : octet count and EtherType of the current frame
//   frame_done, frame_err         : one-cycle pulses for normal completion / FIFO-starvation abort
//   drop_cnt, err_cnt             : saturating counts of filtered frames / aborts
//
// Build option: define RX_TYPE_FILTER_EN to drain (not forward) frames whose EtherType is
// neither IPv4 (0800) nor ARP (0806).

module rx_frame_ctrl #(
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic [15:0] rx_data_count,
  input  logic [15:0] rx_protocol_type,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        rx_rst_n,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] frame_len,
  output logic [15:0] frame_type,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_RELEASE,
    ST_UNLOCK
  } state_t;

  // Terminal counter values: the release timer counts 0..RELEASE_CYCLES-1,
  // the starvation timer aborts on the TIMEOUT_CYCLES-th consecutive empty cycle.
  localparam logic [7:0]  LP_REL_LAST = 8'(RELEASE_CYCLES - 1);
  localparam logic [15:0] LP_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LP_SAT      = 16'hFFFF;

  state_t      r_state;
  logic        r_sync_q1;
  logic        r_sync_q2;
  logic [15:0] r_words;
  logic [15:0] r_timer;
  logic [7:0]  r_rel_cnt;
  logic [31:0] r_m_data;
  logic        r_m_valid;
  logic        r_m_last;
  logic [15:0] r_frame_len;
  logic [15:0] r_frame_type;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [15:0] r_drop_cnt;
  logic [15:0] r_err_cnt;
  logic        r_rx_rst_n;

  logic        w_rdy_s;
  logic        w_filter_reject;
  logic        w_fetch_rd;
  logic        w_drain_rd;
  logic        w_timeout;
  logic        w_xfer;

  // rx_ready comes from the 50 MHz receiver domain; it is a level that stays
  // high until released, so a plain 2-flop synchronizer is sufficient.
  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      r_sync_q1 <= 1'b0;
      r_sync_q2 <= 1'b0;
    end else begin
      r_sync_q1 <= rx_ready;
      r_sync_q2 <= r_sync_q1;
    end
  end

  assign w_rdy_s = r_sync_q2;

`ifdef RX_TYPE_FILTER_EN
  assign w_filter_reject = (rx_protocol_type != 16'h0800) && (rx_protocol_type != 16'h0806);
`else
  assign w_filter_reject = 1'b0;
`endif

  // The read strobe is qualified combinationally by fifo_empty so it can never
  // be raised against an empty FIFO, even if empty rises in the same cycle.
  // FETCH leaves for WAIT on the read, so the strobe lasts exactly one cycle.
  assign w_fetch_rd = (r_state == ST_FETCH) && !fifo_empty;
  assign w_drain_rd = (r_state == ST_DRAIN) && !fifo_empty && (r_words != 16'd0);
  assign fifo_rd_en = w_fetch_rd || w_drain_rd;

  assign w_timeout  = (r_timer == LP_TO_LAST);
  assign w_xfer     = r_m_valid && m_ready;

  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_words      <= '0;
      r_timer      <= '0;
      r_rel_cnt    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_len  <= '0;
      r_frame_type <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_drop_cnt   <= '0;
      r_err_cnt    <= '0;
      r_rx_rst_n   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_rx_rst_n <= 1'b1;
          if (w_rdy_s) begin
            r_state <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          r_frame_len  <= rx_data_count;
          r_frame_type <= rx_protocol_type;
          // Whole 32-bit words only; a 1-3 octet tail is discarded by the FIFO release.
          r_words      <= {2'b00, rx_data_count[15:2]};
          r_timer      <= '0;
          if (rx_data_count[15:2] == 14'd0) begin
            r_state    <= ST_RELEASE;
            r_rx_rst_n <= 1'b0;
            r_rel_cnt  <= '0;
          end else if (w_filter_reject) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (w_fetch_rd) begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_cnt   <= (r_err_cnt == LP_SAT) ? r_err_cnt : r_err_cnt + 16'd1;
            r_state     <= ST_RELEASE;
            r_rx_rst_n  <= 1'b0;
            r_rel_cnt   <= '0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        ST_WAIT: begin
          r_m_data  <= fifo_data;
          r_m_valid <= 1'b1;
          r_m_last  <= (r_words == 16'd1);
          r_state   <= ST_HOLD;
        end

        ST_HOLD: begin
          if (w_xfer) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_words   <= r_words - 16'd1;
            if (r_words == 16'd1) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_RELEASE;
              r_rx_rst_n   <= 1'b0;
              r_rel_cnt    <= '0;
            end else begin
              r_timer <= '0;
              r_state <= ST_FETCH;
            end
          end
        end

        ST_DRAIN: begin
          // Reads back-to-back; words is never 0 here, so a missing
          // strobe always means the FIFO is empty.
          if (w_drain_rd) begin
            r_words <= r_words - 16'd1;
            r_timer <= '0;
            if (r_words == 16'd1) begin
              r_drop_cnt <= (r_drop_cnt == LP_SAT) ? r_drop_cnt : r_drop_cnt + 16'd1;
              r_state    <= ST_RELEASE;
              r_rx_rst_n <= 1'b0;
              r_rel_cnt  <= '0;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_cnt   <= (r_err_cnt == LP_SAT) ? r_err_cnt : r_err_cnt + 16'd1;
            r_state     <= ST_RELEASE;
            r_rx_rst_n  <= 1'b0;
            r_rel_cnt   <= '0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        ST_RELEASE: begin
          // rx_rst_n went low on entry; it is low for RELEASE_CYCLES cycles.
          if (r_rel_cnt == LP_REL_LAST) begin
            r_rx_rst_n <= 1'b1;
            r_state    <= ST_UNLOCK;
          end else begin
            r_rel_cnt <= r_rel_cnt + 8'd1;
          end
        end

        ST_UNLOCK: begin
          // The synchronized flag may still show the frame just released;
          // wait for it to fall so the same frame is not processed twice.
          if (!w_rdy_s) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_rst_n   = r_rx_rst_n;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign frame_len  = r_frame_len;
  assign frame_type = r_frame_type;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign drop_cnt   = r_drop_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frames, a FIFO model that is flushed by rx_rst_n,
// an expected-word queue filled by the stimulus and drained by an independent monitor.
module tb_rx_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rx_ready;
  logic [15:0] rx_data_count;
  logic [15:0] rx_protocol_type;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        rx_rst_n;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] frame_len;
  logic [15:0] frame_type;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  rx_frame_ctrl dut (
    .clk_100_mhz      (clk),
    .rst_n            (rst_n),
    .rx_ready         (rx_ready),
    .rx_data_count    (rx_data_count),
    .rx_protocol_type (rx_protocol_type),
    .fifo_data        (fifo_data),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .rx_rst_n         (rx_rst_n),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .frame_len        (frame_len),
    .frame_type       (frame_type),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .drop_cnt         (drop_cnt),
    .err_cnt          (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // FIFO model: stimulus owns fifo_mem/total, the model owns rdptr.
  logic [31:0] fifo_mem [0:1023];
  int          total = 0;
  int          rdptr = 0;

  // Monitor statistics.
  int          cyc = 0, rd_cnt = 0, xfer_cnt = 0, valid_cnt = 0;
  int          done_cnt = 0, errp_cnt = 0, rel_events = 0;
  int          low_run = 0, last_low = 0, run = 0, last_run = 0;
  int          err_cyc = 0, last_xfer_cyc = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data = '0;

  // Stimulus-side snapshots.
  int          rel0, done0, err0, rd0, xf0, val0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : fifo_model
    logic rd_s, rel_s;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_s  = fifo_rd_en;
      rel_s = !rx_rst_n;
      @(posedge clk);
      #2;
      if (rel_s) rdptr = total;
      else if (rd_s) begin
        fifo_data = fifo_mem[rdptr];
        rdptr++;
      end
      fifo_empty = (rdptr >= total);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_rd_en === 1'b1) begin
        chk("rd_en_vs_empty", 32'(fifo_empty), 32'd0);
        rd_cnt++;
        run++;
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", 32'(m_last), 32'(e.last));
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (m_valid === 1'b1) valid_cnt++;
      if (rst_n && prev_valid && !prev_ready) begin
        chk("stall_m_valid", 32'(m_valid), 32'd1);
        chk("stall_m_data", m_data, prev_data);
      end
      if (frame_done === 1'b1) done_cnt++;
      if (frame_err === 1'b1) begin
        errp_cnt++;
        err_cyc = cyc;
      end
      if (frame_done === 1'b1 || frame_err === 1'b1)
        chk("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
      if (rx_rst_n === 1'b0) low_run++;
      else if (low_run > 0) begin
        last_low = low_run;
        low_run = 0;
        rel_events++;
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
    end
  end

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_mem[total + i] = base + 32'(i);
    total += n;
  endtask

  task automatic snap();
    rel0 = rel_events; done0 = done_cnt; err0 = errp_cnt;
    rd0 = rd_cnt; xf0 = xfer_cnt; val0 = valid_cnt;
  endtask

  task automatic send_frame(input logic [15:0] cnt, input logic [15:0] typ, input int nload,
                            input logic [31:0] base, input int nexp, input bit last_ok,
                            input int stall_at, input int hold_cycles, input int hold_load,
                            input logic [31:0] hold_base);
    int k, stall_left, rd_snap, rd_h, val_h;
    bit stalled;
    @(posedge clk); #1;
    load(nload, base);
    for (int i = 0; i < nexp; i++) exp_q.push_back({last_ok && (i == nexp - 1), base + 32'(i)});
    snap();
    rx_data_count = cnt; rx_protocol_type = typ; m_ready = 1'b1; rx_ready = 1'b1;
    k = 0; stall_left = 0; stalled = 0; rd_snap = 0;
    while (rel_events == rel0 && k < 5000) begin
      @(posedge clk); #1;
      k++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          m_ready = 1'b1;
          chk("stall_extra_reads", 32'(rd_cnt - rd_snap), 32'd1);
        end
      end else if (!stalled && stall_at > 0 && (xfer_cnt - xf0) == stall_at) begin
        stalled = 1; m_ready = 1'b0; stall_left = 10; rd_snap = rd_cnt;
      end
    end
    chk("release_seen", 32'(rel_events - rel0), 32'd1);
    if (hold_cycles > 0) begin
      load(hold_load, hold_base);
      rd_h = rd_cnt; val_h = valid_cnt;
      repeat (hold_cycles) @(posedge clk);
      #1;
      chk("stale_no_read", 32'(rd_cnt - rd_h), 32'd0);
      chk("stale_no_valid", 32'(valid_cnt - val_h), 32'd0);
    end
    rx_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    rst_n = 1'b0; rx_ready = 1'b0; rx_data_count = '0; rx_protocol_type = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset values.
    @(negedge clk);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_frame_type", 32'(frame_type), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rx_rst_n", 32'(rx_rst_n), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rx_rst_n_after_reset", 32'(rx_rst_n), 32'd1);

    // One-cycle reset while a word is held in HOLD.
    @(posedge clk); #1;
    load(4, 32'h0000_0100);
    snap();
    rx_data_count = 16'd16; rx_protocol_type = 16'h0800; m_ready = 1'b0; rx_ready = 1'b1;
    k = 0;
    while (m_valid !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_reached", 32'(m_valid), 32'd1);
    chk("hold_word0", m_data, 32'h0000_0100);
    rst_n = 1'b0; rx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", m_data, 32'd0);
    chk("midrst_frame_len", 32'(frame_len), 32'd0);
    chk("midrst_rx_rst_n", 32'(rx_rst_n), 32'd0);
    chk("midrst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rx_rst_n_back", 32'(rx_rst_n), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - done0), 32'd0);
    chk("midrst_no_err", 32'(errp_cnt - err0), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);

    // 64 octets, IPv4, FIFO pre-filled: 16 words, last on word 16.
    send_frame(16'd64, 16'h0800, 16, 32'h0000_1000, 16, 1'b1, 0, 0, 0, 32'h0);
    chk("f64_done", 32'(done_cnt - done0), 32'd1);
    chk("f64_err", 32'(errp_cnt - err0), 32'd0);
    chk("f64_reads", 32'(rd_cnt - rd0), 32'd16);
    chk("f64_words", 32'(xfer_cnt - xf0), 32'd16);
    chk("f64_release_len", 32'(last_low), 32'd4);
    chk("f64_frame_len", 32'(frame_len), 32'd64);
    chk("f64_frame_type", 32'(frame_type), 32'h0800);
    chk("f64_queue_empty", 32'(exp_q.size()), 32'd0);

    // 67 octets: the 3-octet tail word is never read.
    send_frame(16'd67, 16'h0806, 17, 32'h0000_2000, 16, 1'b1, 0, 0, 0, 32'h0);
    chk("f67_reads", 32'(rd_cnt - rd0), 32'd16);
    chk("f67_done", 32'(done_cnt - done0), 32'd1);
    chk("f67_release_len", 32'(last_low), 32'd4);
    chk("f67_frame_len", 32'(frame_len), 32'd67);
    chk("f67_queue_empty", 32'(exp_q.size()), 32'd0);

    // 10 words with m_ready low for 10 cycles after the 5th transfer.
    send_frame(16'd40, 16'h0800, 10, 32'h0000_3000, 10, 1'b1, 5, 0, 0, 32'h0);
    chk("stall_done", 32'(done_cnt - done0), 32'd1);
    chk("stall_reads", 32'(rd_cnt - rd0), 32'd10);
    chk("stall_words", 32'(xfer_cnt - xf0), 32'd10);
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef RX_TYPE_FILTER_EN
    // IPv6 frame is drained back-to-back and counted as a drop.
    send_frame(16'd60, 16'h86DD, 15, 32'h0000_4000, 0, 1'b0, 0, 0, 0, 32'h0);
    chk("v6_reads", 32'(rd_cnt - rd0), 32'd15);
    chk("v6_burst", 32'(last_run), 32'd15);
    chk("v6_no_valid", 32'(valid_cnt - val0), 32'd0);
    chk("v6_no_done", 32'(done_cnt - done0), 32'd0);
    chk("v6_drop_cnt", 32'(drop_cnt), 32'd1);
`else
    // Without filtering the IPv6 frame is forwarded like any other.
    send_frame(16'd60, 16'h86DD, 15, 32'h0000_4000, 15, 1'b1, 0, 0, 0, 32'h0);
    chk("v6_reads", 32'(rd_cnt - rd0), 32'd15);
    chk("v6_words", 32'(xfer_cnt - xf0), 32'd15);
    chk("v6_done", 32'(done_cnt - done0), 32'd1);
    chk("v6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // 3 octets: zero whole words, straight to release.
    send_frame(16'd3, 16'h0800, 1, 32'h0000_5000, 0, 1'b0, 0, 0, 0, 32'h0);
    chk("f3_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("f3_done", 32'(done_cnt - done0), 32'd0);
    chk("f3_err", 32'(errp_cnt - err0), 32'd0);
    chk("f3_release_len", 32'(last_low), 32'd4);

    // FIFO starves after 5 of 16 words; rx_ready then held high to test UNLOCK.
    send_frame(16'd64, 16'h0800, 5, 32'h0000_6000, 5, 1'b0, 0, 20, 2, 32'h0000_7000);
    chk("to_err_pulse", 32'(errp_cnt - err0), 32'd1);
    chk("to_no_done", 32'(done_cnt - done0), 32'd0);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    chk("to_reads", 32'(rd_cnt - rd0), 32'd5);
    chk("to_latency", 32'(err_cyc - last_xfer_cyc), 32'd1025);
    chk("to_release_len", 32'(last_low), 32'd4);
    chk("to_queue_empty", 32'(exp_q.size()), 32'd0);

    // Normal frame afterwards, using the words loaded during the UNLOCK hold.
    send_frame(16'd8, 16'h0806, 0, 32'h0000_7000, 2, 1'b1, 0, 0, 0, 32'h0);
    chk("post_done", 32'(done_cnt - done0), 32'd1);
    chk("post_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("post_err_cnt", 32'(err_cnt), 32'd1);
    chk("post_frame_type", 32'(frame_type), 32'h0806);
    chk("post_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
